// File: rtl/xnorn_pkg.sv
// xnorn_pkg: shared constants and tree-sizing helpers for the xnorn reduction pipe.
package xnorn_pkg;

    localparam logic MODE_XOR  = 1'b0;
    localparam logic MODE_XNOR = 1'b1;
    localparam int   MAXW      = 256;

    function automatic int levels_f(input int width);
        int n;
        int p;
        n = 0;
        p = 1;
        while (p < width) begin
            p = p * 3;
            n = n + 1;
        end
        return n;
    endfunction

    // Width of the tree after k levels of 3:1 reduction.
    function automatic int lvl_w(input int width, input int k);
        int w;
        w = width;
        for (int i = 0; i < k; i++) w = (w + 2) / 3;
        return w;
    endfunction

    // Bits beyond width contribute nothing, which is the 0 padding of a short group.
    function automatic logic [MAXW-1:0] xor3_reduce(input logic [MAXW-1:0] v, input int width);
        logic [MAXW-1:0] r;
        r = '0;
        for (int j = 0; j < MAXW; j++)
            if (j < width) r[j/3] = r[j/3] ^ v[j];
        return r;
    endfunction

endpackage

// File: rtl/xnorn_level.sv
// xnorn_level: one registered 3:1 XOR tree level; all channels share one valid/MODE pair.
module xnorn_level
    import xnorn_pkg::*;
#(
    parameter int IW  = 3,
    parameter int CH  = 1,
    parameter bit INV = 1'b0
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      EN,
    input  logic [CH*IW-1:0]          D,
    input  logic                      D_VLD,
    input  logic                      D_MODE,
    output logic [CH*((IW+2)/3)-1:0]  Q,
    output logic                      Q_VLD,
    output logic                      Q_MODE
);
    localparam int OW = (IW + 2) / 3;

    logic [CH*OW-1:0] w_red;

    always_comb begin
        logic [MAXW-1:0] w_full;
        w_red  = '0;
        w_full = '0;
        for (int c = 0; c < CH; c++) begin
            w_full = xor3_reduce(MAXW'(D[c*IW +: IW]), IW);
            w_red[c*OW +: OW] = w_full[OW-1:0] ^ (INV ? {OW{D_MODE}} : {OW{1'b0}});
        end
    end

    // Data holds across bubbles; valid and MODE advance on every enabled edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q      <= '0;
            Q_VLD  <= 1'b0;
            Q_MODE <= MODE_XOR;
        end else if (EN) begin
            Q_VLD  <= D_VLD;
            Q_MODE <= D_MODE;
            if (D_VLD) Q <= w_red;
        end
    end

endmodule

// File: rtl/xnorn_pipe.sv
// xnorn_pipe: pipelined multi-channel XOR/XNOR parity reduction with valid/ready
// handshake, global stall and a saturating failure counter.
module xnorn_pipe
    import xnorn_pkg::*;
#(
    parameter int WIDTH    = 9,
    parameter int CHANNELS = 2,
    parameter int CNTW     = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CHANNELS*WIDTH-1:0] A,
    input  logic                      MODE,
    input  logic                      I_VLD,
    output logic                      I_RDY,
    output logic [CHANNELS-1:0]       ZN,
    output logic                      O_VLD,
    input  logic                      O_RDY,
    input  logic                      CLR,
    output logic [CNTW-1:0]           FAIL_CNT
);
    localparam int LEVELS = levels_f(WIDTH);

    logic            w_stall;
    logic [CNTW-1:0] r_cnt;

    assign w_stall = O_VLD & ~O_RDY;
    assign I_RDY   = ~w_stall;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int IW = lvl_w(WIDTH, k - 1);
        localparam int OW = (IW + 2) / 3;
        logic [CHANNELS*IW-1:0] w_d;
        logic                   w_dv;
        logic                   w_dm;
        logic [CHANNELS*OW-1:0] w_q;
        logic                   w_qv;
        logic                   w_qm;
        if (k == 1) begin : g_in
            assign w_d  = A;
            assign w_dv = I_VLD;
            assign w_dm = MODE;
        end else begin : g_mid
            assign w_d  = g_lvl[k-1].w_q;
            assign w_dv = g_lvl[k-1].w_qv;
            assign w_dm = g_lvl[k-1].w_qm;
        end
        // MODE inversion folds into the last register so ZN stays a pure register output.
        xnorn_level #(.IW(IW), .CH(CHANNELS), .INV(k == LEVELS)) u_lvl (
            .CLK    (CLK),
            .RST    (RST),
            .EN     (~w_stall),
            .D      (w_d),
            .D_VLD  (w_dv),
            .D_MODE (w_dm),
            .Q      (w_q),
            .Q_VLD  (w_qv),
            .Q_MODE (w_qm)
        );
    end

    assign ZN    = g_lvl[LEVELS].w_q;
    assign O_VLD = g_lvl[LEVELS].w_qv;

    always_ff @(posedge CLK) begin
        if (RST)
            r_cnt <= '0;
        else if (CLR)
            r_cnt <= '0;
        else if (O_VLD && O_RDY && !(&ZN) && !(&r_cnt))
            r_cnt <= r_cnt + 1'b1;
    end

    assign FAIL_CNT = r_cnt;

endmodule

// File: tb/tb_xnorn_pipe.sv
// tb_xnorn_pipe: scoreboard bench for xnorn_pipe (WIDTH=9, CHANNELS=2, CNTW=2).
module tb_xnorn_pipe;
    localparam int W  = 9;
    localparam int CH = 2;
    localparam int CW = 2;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [CH*W-1:0] A = '0;
    logic            MODE = 1'b0;
    logic            I_VLD = 1'b0;
    logic            I_RDY;
    logic [CH-1:0]   ZN;
    logic            O_VLD;
    logic            O_RDY = 1'b1;
    logic            CLR = 1'b0;
    logic [CW-1:0]   FAIL_CNT;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            m_cnt   = 0;
    logic [CH-1:0] q_exp[$];

    xnorn_pipe #(.WIDTH(W), .CHANNELS(CH), .CNTW(CW)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .A        (A),
        .MODE     (MODE),
        .I_VLD    (I_VLD),
        .I_RDY    (I_RDY),
        .ZN       (ZN),
        .O_VLD    (O_VLD),
        .O_RDY    (O_RDY),
        .CLR      (CLR),
        .FAIL_CNT (FAIL_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CH-1:0] ref_zn(input logic [CH*W-1:0] a, input logic m);
        logic [CH-1:0] z;
        for (int c = 0; c < CH; c++) z[c] = (^a[c*W +: W]) ^ m;
        return z;
    endfunction

    // Predict this edge's transfers, take the edge, then check the counter.
    task automatic tick();
        logic          push;
        logic [CH-1:0] e;
        #1;
        push = I_VLD && I_RDY;
        if (RST) begin
            m_cnt = 0;
            q_exp.delete();
        end else begin
            if (O_VLD && O_RDY) begin
                if (q_exp.size() == 0) begin
                    chk("orphan_beat", 32'(O_VLD), 32'd0);
                end else begin
                    e = q_exp.pop_front();
                    chk("zn", 32'(ZN), 32'(e));
                    if (!CLR && e != '1 && m_cnt != 3) m_cnt++;
                end
            end
            if (CLR) m_cnt = 0;
            if (push) q_exp.push_back(ref_zn(A, MODE));
        end
        @(posedge CLK);
        #1;
        chk("fail_cnt", 32'(FAIL_CNT), 32'(m_cnt));
    endtask

    task automatic drain();
        for (int g = 0; g < 20 && q_exp.size() != 0; g++) tick();
        chk("drain_empty", 32'(q_exp.size()), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        RST = 1'b0;
        chk("rst_ovld", 32'(O_VLD), 32'd0);
        chk("rst_irdy", 32'(I_RDY), 32'd1);
        chk("rst_zn", 32'(ZN), 32'd0);
        chk("rst_cnt", 32'(FAIL_CNT), 32'd0);

        // XNOR beat: ch0 even -> 1, ch1 odd -> 0
        A = {9'h001, 9'h000}; MODE = 1'b1; I_VLD = 1'b1;
        tick();
        I_VLD = 1'b0;
        chk("lat_ovld_1", 32'(O_VLD), 32'd0);
        tick();
        chk("lat_ovld_2", 32'(O_VLD), 32'd1);
        chk("xnor_zn", 32'(ZN), 32'b01);
        tick();
        chk("cnt_after_fail", 32'(FAIL_CNT), 32'd1);

        A = {9'h001, 9'h000}; MODE = 1'b0; I_VLD = 1'b1;
        tick();
        I_VLD = 1'b0;
        tick();
        chk("xor_ovld", 32'(O_VLD), 32'd1);
        chk("xor_zn", 32'(ZN), 32'b10);
        drain();

        for (int i = 0; i < 8; i++) begin
            A = CH*W'($urandom); MODE = 1'($urandom); I_VLD = 1'b1;
            tick();
            if (i >= 1) chk("stream_ovld", 32'(O_VLD), 32'd1);
        end
        I_VLD = 1'b0;
        drain();

        A = {9'h0a5, 9'h13c}; MODE = 1'b1; I_VLD = 1'b1;
        tick();
        A = {9'h1ff, 9'h007}; MODE = 1'b0;
        tick();
        I_VLD = 1'b0;
        O_RDY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_irdy", 32'(I_RDY), 32'd0);
            chk("stall_ovld", 32'(O_VLD), 32'd1);
            chk("stall_zn", 32'(ZN), 32'(q_exp[0]));
            chk("stall_depth", 32'(q_exp.size()), 32'd2);
        end
        O_RDY = 1'b1;
        tick();
        chk("release_ovld", 32'(O_VLD), 32'd1);
        chk("release_zn", 32'(ZN), 32'(q_exp[0]));
        tick();
        chk("release_done", 32'(O_VLD), 32'd0);
        chk("release_empty", 32'(q_exp.size()), 32'd0);

        A = {9'h001, 9'h000}; MODE = 1'b1; I_VLD = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        I_VLD = 1'b0;
        drain();
        chk("sat_cnt", 32'(FAIL_CNT), 32'd3);

        I_VLD = 1'b1;
        tick();
        I_VLD = 1'b0;
        tick();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        chk("clr_cnt", 32'(FAIL_CNT), 32'd0);

        A = {9'h003, 9'h000}; MODE = 1'b1; I_VLD = 1'b1;
        tick();
        I_VLD = 1'b0;
        drain();
        chk("pass_nocount", 32'(FAIL_CNT), 32'd0);

        A = {9'h001, 9'h000}; MODE = 1'b1; I_VLD = 1'b1;
        tick();
        tick();
        I_VLD = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mid_rst_ovld", 32'(O_VLD), 32'd0);
        chk("mid_rst_zn", 32'(ZN), 32'd0);
        chk("mid_rst_cnt", 32'(FAIL_CNT), 32'd0);
        chk("mid_rst_irdy", 32'(I_RDY), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ghost_ovld", 32'(O_VLD), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
